spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
Shares the single SPI master engine (CLK domain, 16 MHz) between NUM_REQ on-chip requesters. Arbitrates round-robin and sequences one byte transfer per grant: handshake, engine start, completion wait, timeout, then a minimum idle gap. Sits between the requester logic and the SPI engine that drives clk_output/mosi_output/sel_output.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_W, 8, transfer word width
GAP_CYCLES, 4, CLK cycles idle after each transfer before next arbitration (0 allowed)
TIMEOUT_CYCLES, 1024, CLK cycles allowed between spi_start and spi_done before abort
ID_W, $clog2(NUM_REQ), grant index width (min 1)

Ports:
CLK  in  1  system clock, single clock domain
RST_N  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester transfer request; held until accepted
req_ready  out  NUM_REQ  one-hot accept, combinational in IDLE
req_wdata  in  NUM_REQ*DATA_W  packed TX words, requester i at [i*DATA_W +: DATA_W]
rsp_valid  out  NUM_REQ  one-hot 1-cycle completion pulse to granted requester
rsp_rdata  out  DATA_W  RX word, valid with rsp_valid
rsp_err  out  1  high with rsp_valid when transfer timed out
spi_start  out  1  1-cycle start pulse to SPI engine
spi_wdata  out  DATA_W  TX word to engine, stable from spi_start to spi_done
spi_busy  in  1  engine busy
spi_done  in  1  engine 1-cycle completion pulse
spi_rdata  in  DATA_W  engine RX word, valid with spi_done
grant_id  out  ID_W  index of current/last granted requester
arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (RST_N=0 at rising CLK edge): state=IDLE; all outputs 0; pointer set so requester 0 has top priority (last_grant=NUM_REQ-1); timers 0. Reset mid-transfer aborts silently: no rsp_valid, no spi_start; engine handles its own reset.
- States: IDLE, START, WAIT, GAP.
- IDLE: if any req_valid, winner = first set bit searching from last_grant+1 with wrap; req_ready[winner]=1 combinationally (only that bit). At the edge: latch req_wdata slice into spi_wdata, grant_id<=winner, last_grant<=winner, ->START. No req_valid: stay.
- START: spi_start=1 for exactly one cycle when spi_busy=0, then ->WAIT, timer cleared. While spi_busy=1: hold in START, spi_start=0, no timeout.
- WAIT: timer increments each cycle. spi_done=1: rsp_rdata<=spi_rdata, rsp_valid[grant_id]=1 next cycle, rsp_err=0, ->GAP. timer reaches TIMEOUT_CYCLES-1 without done: rsp_valid[grant_id]=1, rsp_err=1, rsp_rdata=0, ->GAP. spi_done and timeout in same cycle: done wins (rsp_err=0).
- spi_done outside WAIT is ignored.
- GAP: count GAP_CYCLES cycles, then ->IDLE. GAP_CYCLES=0: GAP lasts zero cycles, direct to IDLE.
- Latency (spi_busy=0): accept edge -> spi_start high next cycle; spi_done cycle -> rsp_valid next cycle.
- req_valid dropped before req_ready: no grant, no error. Requester asserting req_valid while granted but after acceptance: treated as a new request after GAP.
- rsp_valid, rsp_err, spi_start, req_ready never high outside their stated states. All outputs registered except req_ready.

Decomposition:
- Package spi_ctrl_pkg: state enum (IDLE, START, WAIT, GAP), default DATA_W, timeout/gap defaults.
- Sub-module rr_arbiter: pure combinational; inputs req vector and last_grant; outputs one-hot grant and index. Reused by other shared-resource controllers.

Test Plan:
- req_valid=001, wdata0=0xA5, engine loops back after 20 cycles -> spi_start 1 cycle after accept, spi_wdata=0xA5, rsp_valid=001 with rsp_rdata=0xA5, rsp_err=0, next accept no sooner than 4 cycles after rsp.
- req_valid=111 held, each drop after its rsp -> grant order 0,1,2; repeat with 111 after last_grant=1 -> order 2,0,1.
- Engine never pulses spi_done -> rsp_valid and rsp_err high exactly 1024 cycles after spi_start; arbiter returns to IDLE after gap.
- spi_busy=1 for 50 cycles after accept -> spi_start held off 50 cycles, no timeout, then single pulse.
- spi_done on the timeout-expiry cycle -> rsp_err=0, rsp_rdata=spi_rdata.
- RST_N=0 for one cycle during WAIT -> all outputs 0 next cycle, no rsp_valid, next grant goes to requester 0 when 111 requested.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer arbiter and related controllers.
package spi_ctrl_pkg;

    localparam int unsigned DEF_DATA_W         = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
    localparam int unsigned DEF_GAP_CYCLES     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } xfer_state_e;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request after last_grant, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    int unsigned cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(last_grant) + i) % NUM_REQ;
            if (!grant_valid && req[ID_W'(cand)]) begin
                grant[ID_W'(cand)] = 1'b1;
                grant_idx          = ID_W'(cand);
                grant_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master engine among NUM_REQ requesters, one byte transfer per grant.
module spi_xfer_arbiter import spi_ctrl_pkg::*; #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned ID_W           = id_width(NUM_REQ)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_wdata,
    input  logic                      spi_busy,
    input  logic                      spi_done,
    input  logic [DATA_W-1:0]         spi_rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      arb_busy
);

    localparam int unsigned TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    xfer_state_e         state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [ID_W-1:0]     grant_id_d;
    logic [DATA_W-1:0]   spi_wdata_d, rsp_rdata_d, win_data;
    logic [NUM_REQ-1:0]  rsp_valid_d, win_onehot;
    logic                spi_start_d, rsp_err_d, arb_busy_d;
    logic [ID_W-1:0]     win_idx;
    logic                win_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant       (win_onehot),
        .grant_idx   (win_idx),
        .grant_valid (win_valid)
    );

    assign req_ready = (state_q == IDLE) ? win_onehot : '0;

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) win_data = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Next-state and next-output logic; timer counts cycles since the spi_start pulse.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        gap_d        = gap_q;
        grant_id_d   = grant_id;
        spi_wdata_d  = spi_wdata;
        rsp_rdata_d  = rsp_rdata;
        rsp_valid_d  = '0;
        rsp_err_d    = 1'b0;
        spi_start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    spi_wdata_d  = win_data;
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                    spi_start_d  = !spi_busy;
                    timer_d      = '0;
                    state_d      = START;
                end
            end
            START: begin
                if (spi_start) begin
                    timer_d = timer_q + TMR_W'(1);
                    state_d = WAIT;
                end else if (!spi_busy) begin
                    spi_start_d = 1'b1;
                    timer_d     = '0;
                end
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                gap_d   = '0;
                if (spi_done) begin
                    rsp_valid_d = NUM_REQ'(1) << grant_id;
                    rsp_rdata_d = spi_rdata;
                    state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = NUM_REQ'(1) << grant_id;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) state_d = IDLE;
                else                           gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            timer_q      <= '0;
            gap_q        <= '0;
            grant_id     <= '0;
            spi_wdata    <= '0;
            rsp_rdata    <= '0;
            rsp_valid    <= '0;
            rsp_err      <= 1'b0;
            spi_start    <= 1'b0;
            arb_busy     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
            grant_id     <= grant_id_d;
            spi_wdata    <= spi_wdata_d;
            rsp_rdata    <= rsp_rdata_d;
            rsp_valid    <= rsp_valid_d;
            rsp_err      <= rsp_err_d;
            spi_start    <= spi_start_d;
            arb_busy     <= arb_busy_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter with a behavioural SPI engine model.
module tb_spi_xfer_arbiter;

    localparam int GAP = 4;

    typedef struct {
        logic [1:0] id;
        logic [7:0] wdata;
        int         lat;
    } start_t;

    typedef struct {
        logic [2:0] onehot;
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } rsp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [23:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        spi_start;
    logic [7:0]  spi_wdata;
    logic        eng_busy, hold_busy;
    logic        spi_done;
    logic [7:0]  spi_rdata;
    logic [1:0]  grant_id;
    logic        arb_busy;

    logic        eng_loop;
    int          eng_delay;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    start_t exp_start[$];
    rsp_t   exp_rsp[$];

    spi_xfer_arbiter dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .spi_start (spi_start),
        .spi_wdata (spi_wdata),
        .spi_busy  (eng_busy | hold_busy),
        .spi_done  (spi_done),
        .spi_rdata (spi_rdata),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    always #31 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine model: loops spi_wdata back on spi_done eng_delay cycles after spi_start.
    initial begin
        logic [7:0] cap;
        int d;
        eng_busy = 1'b0; spi_done = 1'b0; spi_rdata = 8'h00;
        forever begin
            @(negedge CLK);
            if (spi_start && RST_N && eng_loop) begin
                cap = spi_wdata;
                d   = eng_delay;
                @(posedge CLK); #1;
                eng_busy = 1'b1;
                repeat (d - 1) @(posedge CLK);
                #1;
                spi_done = 1'b1; spi_rdata = cap;
                @(posedge CLK); #1;
                spi_done = 1'b0; spi_rdata = 8'h00; eng_busy = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT accepts, starts or responds.
    initial begin
        int acc_cyc, rsp_cyc;
        bit have_rsp;
        start_t es;
        rsp_t   er;
        acc_cyc = 0; rsp_cyc = 0; have_rsp = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                have_rsp = 0;
            end else begin
                if (|(req_ready & req_valid)) begin
                    acc_cyc = cyc;
                    if (have_rsp) check("gap_before_accept", 32'((cyc - rsp_cyc) >= GAP), 32'd1);
                end
                if (spi_start) begin
                    if (exp_start.size() == 0) check("unexpected_spi_start", 32'd1, 32'd0);
                    else begin
                        es = exp_start.pop_front();
                        check("start_grant_id", 32'(grant_id), 32'(es.id));
                        check("start_wdata", 32'(spi_wdata), 32'(es.wdata));
                        check("start_latency", 32'(cyc - acc_cyc), 32'(es.lat));
                    end
                    rsp_cyc = cyc;
                end
                if (|rsp_valid) begin
                    if (exp_rsp.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    else begin
                        er = exp_rsp.pop_front();
                        check("rsp_onehot", 32'(rsp_valid), 32'(er.onehot));
                        check("rsp_rdata", 32'(rsp_rdata), 32'(er.rdata));
                        check("rsp_err", 32'(rsp_err), 32'(er.err));
                        check("rsp_latency", 32'(cyc - rsp_cyc), 32'(er.lat));
                    end
                    rsp_cyc  = cyc;
                    have_rsp = 1;
                end
            end
        end
    end

    task automatic wait_rsp(output logic [2:0] who);
        who = 3'b000;
        for (int i = 0; i < 1200; i++) begin
            @(negedge CLK);
            if (|rsp_valid) begin
                who = rsp_valid;
                return;
            end
        end
        check("rsp_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!arb_busy) return;
        end
        check("idle_wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        check({tag, "_spi_start"}, 32'(spi_start), 32'd0);
        check({tag, "_spi_wdata"}, 32'(spi_wdata), 32'd0);
        check({tag, "_grant_id"},  32'(grant_id),  32'd0);
        check({tag, "_arb_busy"},  32'(arb_busy),  32'd0);
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] wd, input int slat,
                        input logic [7:0] rd, input logic err, input int rlat);
        exp_start.push_back('{id: id, wdata: wd, lat: slat});
        exp_rsp.push_back('{onehot: 3'(3'b001 << id), rdata: rd, err: err, lat: rlat});
    endtask

    // Hold a set of requests and drop each one once its response arrives.
    task automatic serve_all(input logic [2:0] mask);
        logic [2:0] who;
        @(posedge CLK); #1;
        req_valid = mask;
        while (req_valid != 3'b000) begin
            wait_rsp(who);
            if (who == 3'b000) req_valid = 3'b000;
            else               req_valid = req_valid & ~who;
        end
        wait_idle();
    endtask

    initial begin
        logic [2:0] who;
        RST_N = 1'b0; req_valid = 3'b000; req_wdata = 24'h0;
        hold_busy = 1'b0; eng_loop = 1'b1; eng_delay = 20;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero_outputs("reset");
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // Round robin after reset: 0,1,2.
        req_wdata = {8'h33, 8'h22, 8'h11};
        push(2'd0, 8'h11, 1, 8'h11, 1'b0, 21);
        push(2'd1, 8'h22, 1, 8'h22, 1'b0, 21);
        push(2'd2, 8'h33, 1, 8'h33, 1'b0, 21);
        serve_all(3'b111);

        // Single request from requester 0 with loopback.
        req_wdata[7:0] = 8'hA5;
        push(2'd0, 8'hA5, 1, 8'hA5, 1'b0, 21);
        serve_all(3'b001);

        // Engine busy for 50 cycles from the accept cycle holds off spi_start.
        req_wdata[15:8] = 8'h3C;
        push(2'd1, 8'h3C, 51, 8'h3C, 1'b0, 21);
        @(posedge CLK); #1;
        hold_busy = 1'b1; req_valid = 3'b010;
        @(posedge CLK); #1;
        req_valid = 3'b000;
        repeat (49) @(posedge CLK);
        #1;
        hold_busy = 1'b0;
        wait_rsp(who);
        wait_idle();

        // last_grant is now 1: order 2,0,1.
        req_wdata = {8'h77, 8'h66, 8'h55};
        push(2'd2, 8'h77, 1, 8'h77, 1'b0, 21);
        push(2'd0, 8'h55, 1, 8'h55, 1'b0, 21);
        push(2'd1, 8'h66, 1, 8'h66, 1'b0, 21);
        serve_all(3'b111);

        // Engine never completes: timeout response 1024 cycles after spi_start.
        eng_loop = 1'b0;
        req_wdata[23:16] = 8'h5A;
        push(2'd2, 8'h5A, 1, 8'h00, 1'b1, 1024);
        serve_all(3'b100);
        check("idle_after_timeout", 32'(arb_busy), 32'd0);

        // spi_done on the expiry cycle: done wins.
        eng_loop = 1'b1; eng_delay = 1023;
        req_wdata[7:0] = 8'hC3;
        push(2'd0, 8'hC3, 1, 8'hC3, 1'b0, 1024);
        serve_all(3'b001);

        // Reset during WAIT aborts silently, then requester 0 wins.
        eng_loop = 1'b0;
        req_wdata[15:8] = 8'h99;
        exp_start.push_back('{id: 2'd1, wdata: 8'h99, lat: 1});
        @(posedge CLK); #1;
        req_valid = 3'b010;
        @(posedge CLK); #1;
        req_valid = 3'b000;
        repeat (10) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check_zero_outputs("midreset");
        eng_loop = 1'b1; eng_delay = 5;
        req_wdata = {8'hEE, 8'hDD, 8'hBB};
        push(2'd0, 8'hBB, 1, 8'hBB, 1'b0, 6);
        @(posedge CLK); #1;
        req_valid = 3'b111;
        wait_rsp(who);
        req_valid = 3'b000;
        wait_idle();

        repeat (40) @(posedge CLK);
        @(negedge CLK);
        check("start_queue_drained", 32'(exp_start.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #(62 * 20000);
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
